// File: rtl/ahb_sram_slave.sv
// ahb_sram_slave: AHB-Lite word-organised SRAM slave with byte-lane writes,
// a parameterised number of wait states per transfer and an optional
// two-cycle ERROR response.
// Build option: define AHB_SLAVE_ERR_EN to enable the ERROR response for
// illegal sizes, misaligned accesses and out-of-range word indices. When it is
// undefined, HSIZE above word is treated as word, misaligned low bits are
// forced to alignment and the word index wraps modulo MEM_DEPTH.
module ahb_sram_slave #(
  parameter int ADDR_WIDTH  = 8,
  parameter int DATA_WIDTH  = 32,
  parameter int MEM_DEPTH   = 64,
  parameter int WAIT_STATES = 0
) (
  input  logic                  i_hclk,
  input  logic                  i_hreset,
  input  logic                  i_hsel,
  input  logic [31:0]           i_haddr,
  input  logic [1:0]            i_htrans,
  input  logic                  i_hwrite,
  input  logic [2:0]            i_hsize,
  input  logic [DATA_WIDTH-1:0] i_hwdata,
  input  logic                  i_hready,
  output logic [DATA_WIDTH-1:0] o_hrdata,
  output logic                  o_hreadyout,
  output logic                  o_hresp
);

  localparam int IDX_W = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam int NUM_LANES = DATA_WIDTH / 8;
  // Counter preload: the WAIT state is occupied for WAIT_STATES cycles (N-1 .. 0)
  localparam logic [3:0] WS_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_WAIT = 3'd1,
    S_DATA = 3'd2,
    S_ERR1 = 3'd3,
    S_ERR2 = 3'd4
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [3:0]            r_cnt;
  logic [3:0]            w_cnt_nxt;
  logic                  w_capture;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic                  r_write;
  logic [1:0]            r_size;
  logic [DATA_WIDTH-1:0] r_mem [MEM_DEPTH];

  logic                  w_addr_phase;
  logic                  w_illegal;
  logic [1:0]            w_size_eff;
  logic [ADDR_WIDTH-1:0] w_addr_eff;
  logic [IDX_W-1:0]      w_mem_idx;
  logic [3:0]            w_be;
  logic                  w_unused;

  // Address bits above ADDR_WIDTH belong to the decoder
  assign w_unused = ^i_haddr[31:ADDR_WIDTH];

  // A transfer starts only on a selected, ready NONSEQ/SEQ address phase
  assign w_addr_phase = i_hsel & i_hready & i_htrans[1];

`ifdef AHB_SLAVE_ERR_EN
  // Classify the incoming address phase as illegal (size, alignment, range)
  always_comb begin
    w_illegal = 1'b0;
    if (i_hsize > 3'b010) begin
      w_illegal = 1'b1;
    end else if ((i_hsize == 3'b001) && i_haddr[0]) begin
      w_illegal = 1'b1;
    end else if ((i_hsize == 3'b010) && (i_haddr[1:0] != 2'b00)) begin
      w_illegal = 1'b1;
    end else if (32'(i_haddr[ADDR_WIDTH-1:2]) >= 32'(MEM_DEPTH)) begin
      w_illegal = 1'b1;
    end else begin
      w_illegal = 1'b0;
    end
  end
`else
  assign w_illegal = 1'b0;
`endif

  // Normalise size and align the address so the captured phase is always legal
  always_comb begin
    w_size_eff = (i_hsize[2] || (i_hsize[1:0] == 2'b11)) ? 2'b10 : i_hsize[1:0];
    w_addr_eff = i_haddr[ADDR_WIDTH-1:0];
    if (w_size_eff == 2'b10) begin
      w_addr_eff[1:0] = 2'b00;
    end else if (w_size_eff == 2'b01) begin
      w_addr_eff[0] = 1'b0;
    end else begin
      w_addr_eff[0] = i_haddr[0];
    end
  end

  // Next-state and wait counter; IDLE, DATA and ERR2 may accept a new phase
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_capture   = 1'b0;
    case (r_state)
      S_IDLE, S_DATA, S_ERR2: begin
        if (w_addr_phase) begin
          w_capture = 1'b1;
          if (w_illegal) begin
            w_state_nxt = S_ERR1;
          end else if (WAIT_STATES > 0) begin
            w_state_nxt = S_WAIT;
            w_cnt_nxt   = WS_LOAD;
          end else begin
            w_state_nxt = S_DATA;
          end
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_WAIT: begin
        if (r_cnt == 4'd0) begin
          w_state_nxt = S_DATA;
        end else begin
          w_cnt_nxt = r_cnt - 4'd1;
        end
      end
      S_ERR1:  w_state_nxt = S_ERR2;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State register and wait counter
  always_ff @(posedge i_hclk) begin
    if (i_hreset) begin
      r_state <= S_IDLE;
      r_cnt   <= 4'd0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Capture the accepted address phase for use in the data phase
  always_ff @(posedge i_hclk) begin
    if (i_hreset) begin
      r_addr  <= {ADDR_WIDTH{1'b0}};
      r_write <= 1'b0;
      r_size  <= 2'b00;
    end else if (w_capture) begin
      r_addr  <= w_addr_eff;
      r_write <= i_hwrite;
      r_size  <= w_size_eff;
    end
  end

  assign w_mem_idx = IDX_W'(32'(r_addr[ADDR_WIDTH-1:2]) % 32'(MEM_DEPTH));

  // Little-endian byte-lane enables from captured size and low address bits
  always_comb begin
    w_be = 4'b0000;
    case (r_size)
      2'b00:   w_be = 4'b0001 << r_addr[1:0];
      2'b01:   w_be = r_addr[1] ? 4'b1100 : 4'b0011;
      default: w_be = 4'b1111;
    endcase
  end

  // Memory: cleared on reset, enabled lanes committed at the end of a write DATA cycle
  always_ff @(posedge i_hclk) begin
    if (i_hreset) begin
      for (int i = 0; i < MEM_DEPTH; i++) begin
        r_mem[i] <= {DATA_WIDTH{1'b0}};
      end
    end else if ((r_state == S_DATA) && r_write) begin
      for (int b = 0; b < NUM_LANES; b++) begin
        if (w_be[b]) begin
          r_mem[w_mem_idx][8*b +: 8] <= i_hwdata[8*b +: 8];
        end
      end
    end
  end

  // Outputs decoded from state registers only; read data is zero outside a read DATA cycle
  assign o_hreadyout = (r_state != S_WAIT) && (r_state != S_ERR1);
  assign o_hrdata    = ((r_state == S_DATA) && !r_write) ? r_mem[w_mem_idx]
                                                         : {DATA_WIDTH{1'b0}};
`ifdef AHB_SLAVE_ERR_EN
  assign o_hresp = (r_state == S_ERR1) || (r_state == S_ERR2);
`else
  assign o_hresp = 1'b0;
`endif

endmodule

// File: tb/tb_ahb_sram_slave.sv
// Directed testbench for ahb_sram_slave: one zero-wait instance and one
// three-wait-state instance sharing the bus, each with its own HSEL and with
// HREADY looped back from its own HREADYOUT.
module tb_ahb_sram_slave;

  logic        clk = 1'b0;
  logic        hreset;
  logic        hsel0;
  logic        hsel3;
  logic [31:0] haddr;
  logic [1:0]  htrans;
  logic        hwrite;
  logic [2:0]  hsize;
  logic [31:0] hwdata;
  logic [31:0] hrdata0;
  logic [31:0] hrdata3;
  logic        hreadyout0;
  logic        hreadyout3;
  logic        hresp0;
  logic        hresp3;

  int total = 0;
  int bad   = 0;

  localparam logic [1:0] T_IDLE = 2'b00;
  localparam logic [1:0] T_BUSY = 2'b01;
  localparam logic [1:0] T_NSEQ = 2'b10;
  localparam logic [2:0] SZ_B   = 3'b000;
  localparam logic [2:0] SZ_H   = 3'b001;
  localparam logic [2:0] SZ_W   = 3'b010;

  always #5 clk = ~clk;

  ahb_sram_slave #(.WAIT_STATES(0)) u_dut0 (
    .i_hclk      (clk),
    .i_hreset    (hreset),
    .i_hsel      (hsel0),
    .i_haddr     (haddr),
    .i_htrans    (htrans),
    .i_hwrite    (hwrite),
    .i_hsize     (hsize),
    .i_hwdata    (hwdata),
    .i_hready    (hreadyout0),
    .o_hrdata    (hrdata0),
    .o_hreadyout (hreadyout0),
    .o_hresp     (hresp0)
  );

  ahb_sram_slave #(.WAIT_STATES(3)) u_dut3 (
    .i_hclk      (clk),
    .i_hreset    (hreset),
    .i_hsel      (hsel3),
    .i_haddr     (haddr),
    .i_htrans    (htrans),
    .i_hwrite    (hwrite),
    .i_hsize     (hsize),
    .i_hwdata    (hwdata),
    .i_hready    (hreadyout3),
    .o_hrdata    (hrdata3),
    .o_hreadyout (hreadyout3),
    .o_hresp     (hresp3)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    hsel0  = 1'b0;
    hsel3  = 1'b0;
    htrans = T_IDLE;
    hwrite = 1'b0;
    haddr  = 32'h0;
    hsize  = SZ_W;
  endtask

  task automatic aphase(input logic s0, input logic s3, input logic [31:0] a,
                        input logic w, input logic [2:0] sz);
    hsel0  = s0;
    hsel3  = s3;
    htrans = T_NSEQ;
    haddr  = a;
    hwrite = w;
    hsize  = sz;
  endtask

  // Zero-wait write on instance 0: address phase then data phase
  task automatic wr0(input logic [31:0] a, input logic [2:0] sz, input logic [31:0] d);
    aphase(1'b1, 1'b0, a, 1'b1, sz);
    tick();
    idle();
    hwdata = d;
    tick();
  endtask

  // Zero-wait read on instance 0 with data checked in the data phase
  task automatic rd0(input string tag, input logic [31:0] a, input logic [31:0] exp);
    aphase(1'b1, 1'b0, a, 1'b0, SZ_W);
    tick();
    idle();
    chk(tag, hrdata0, exp);
    chk({tag, "_rdy"}, {31'b0, hreadyout0}, 32'd1);
    tick();
  endtask

  initial begin
    idle();
    hwdata = 32'h0;
    hreset = 1'b1;
    tick();
    tick();
    chk("rst_rdy0", {31'b0, hreadyout0}, 32'd1);
    chk("rst_resp0", {31'b0, hresp0}, 32'd0);
    chk("rst_rdata0", hrdata0, 32'h0);
    chk("rst_rdy3", {31'b0, hreadyout3}, 32'd1);
    hreset = 1'b0;
    tick();

    rd0("rd04_after_rst", 32'h04, 32'h0);

    // Write then immediate read of the same word (read-after-write bypass through memory)
    aphase(1'b1, 1'b0, 32'h10, 1'b1, SZ_W);
    tick();
    hwdata = 32'hDEADBEEF;
    aphase(1'b1, 1'b0, 32'h10, 1'b0, SZ_W);
    chk("raw_wr_rdy", {31'b0, hreadyout0}, 32'd1);
    chk("raw_wr_rdata_zero", hrdata0, 32'h0);
    tick();
    idle();
    chk("raw_rd_data", hrdata0, 32'hDEADBEEF);
    chk("raw_rd_rdy", {31'b0, hreadyout0}, 32'd1);
    tick();
    chk("idle_rdata_zero", hrdata0, 32'h0);

    // Byte and halfword lane writes
    wr0(32'h10, SZ_W, 32'h11223344);
    wr0(32'h13, SZ_B, 32'hAAAAAAAA);
    rd0("byte_lane3", 32'h10, 32'hAA223344);
    wr0(32'h12, SZ_H, 32'h55665566);
    rd0("half_upper", 32'h10, 32'h55663344);
    wr0(32'h11, SZ_B, 32'h77777777);
    rd0("byte_lane1", 32'h10, 32'h55667744);
    rd0("neighbour_untouched", 32'h14, 32'h0);

    // Selected IDLE/BUSY phases give a zero-wait OKAY with no wait states
    hsel3  = 1'b1;
    htrans = T_BUSY;
    haddr  = 32'h20;
    tick();
    chk("busy_rdy3", {31'b0, hreadyout3}, 32'd1);
    idle();
    tick();

    // Three-wait-state write, HSEL dropped during the waits
    aphase(1'b0, 1'b1, 32'h20, 1'b1, SZ_W);
    tick();
    idle();
    hwdata = 32'hCAFEF00D;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("ws3_wr_wait%0d", k), {31'b0, hreadyout3}, 32'd0);
      tick();
    end
    chk("ws3_wr_data_rdy", {31'b0, hreadyout3}, 32'd1);
    tick();

    // Three-wait-state read; during the waits HSEL is low while another NONSEQ sits on the bus
    aphase(1'b0, 1'b1, 32'h20, 1'b0, SZ_W);
    tick();
    hsel3 = 1'b0;
    haddr = 32'h24;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("ws3_rd_wait%0d_rdy", k), {31'b0, hreadyout3}, 32'd0);
      chk($sformatf("ws3_rd_wait%0d_data", k), hrdata3, 32'h0);
      tick();
    end
    idle();
    chk("ws3_rd_rdy", {31'b0, hreadyout3}, 32'd1);
    chk("ws3_rd_data", hrdata3, 32'hCAFEF00D);
    tick();
    chk("ws3_after_rdy", {31'b0, hreadyout3}, 32'd1);
    chk("ws3_after_data", hrdata3, 32'h0);

    // Misaligned word write to 0x02
    wr0(32'h00, SZ_W, 32'h01020304);
    aphase(1'b1, 1'b0, 32'h02, 1'b1, SZ_W);
    tick();
    idle();
    hwdata = 32'hFFFFFFFF;
`ifdef AHB_SLAVE_ERR_EN
    chk("err1_rdy", {31'b0, hreadyout0}, 32'd0);
    chk("err1_resp", {31'b0, hresp0}, 32'd1);
    tick();
    chk("err2_rdy", {31'b0, hreadyout0}, 32'd1);
    chk("err2_resp", {31'b0, hresp0}, 32'd1);
    tick();
    chk("err_done_resp", {31'b0, hresp0}, 32'd0);
    rd0("err_mem_unchanged", 32'h00, 32'h01020304);
`else
    chk("misalign_rdy", {31'b0, hreadyout0}, 32'd1);
    chk("misalign_resp", {31'b0, hresp0}, 32'd0);
    tick();
    rd0("misalign_aligned", 32'h00, 32'hFFFFFFFF);
`endif

    // Reset asserted during the wait phase of a write to 0x30
    aphase(1'b0, 1'b1, 32'h30, 1'b1, SZ_W);
    tick();
    idle();
    hwdata = 32'h12345678;
    tick();
    hreset = 1'b1;
    tick();
    chk("midrst_rdy3", {31'b0, hreadyout3}, 32'd1);
    chk("midrst_resp3", {31'b0, hresp3}, 32'd0);
    hreset = 1'b0;
    tick();
    tick();
    aphase(1'b0, 1'b1, 32'h30, 1'b0, SZ_W);
    tick();
    idle();
    for (int k = 0; k < 3; k++) begin
      tick();
    end
    chk("midrst_rd_rdy", {31'b0, hreadyout3}, 32'd1);
    chk("midrst_rd_data", hrdata3, 32'h0);
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
